// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial packed-BCD adder/subtractor.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Nine's complement of one BCD digit. Non-BCD inputs wrap to values above 9,
  // so they remain detectable as invalid downstream.
  function automatic logic [3:0] bcd_nines(input logic [3:0] d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit decimal-correcting adder: a_i + bd_i + cin_i with +6 correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] bd_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic       cout_o,
  output logic       invalid_o
);

  logic [4:0] t;

  // Binary sum, decimal correction and invalid-digit detection.
  // bd_i is either b or 9-b; both map b>9 onto values >9, so checking bd_i suffices.
  always_comb begin
    t = {1'b0, a_i} + {1'b0, bd_i} + {4'b0000, cin_i};
    if (t > {1'b0, BCD_MAX}) begin
      digit_o = t[3:0] + BCD_CORR;
      cout_o  = 1'b1;
    end else begin
      digit_o = t[3:0];
      cout_o  = 1'b0;
    end
    invalid_o = (a_i > BCD_MAX) || (bd_i > BCD_MAX);
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS) + 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  bcd_state_t    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic          sub_q, sub_d, c_q, c_d, errf_q, errf_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d, err_q, err_d;

  logic [3:0]    bd, dig;
  logic          dig_c, dig_inv;
  logic [W-1:0]  dig_ext;

  // Operand B digit, nine's-complemented for subtraction.
  always_comb begin
    bd = sub_q ? bcd_nines(b_q[3:0]) : b_q[3:0];
  end

  bcd_digit_add u_digit (
    .a_i       (a_q[3:0]),
    .bd_i      (bd),
    .cin_i     (c_q),
    .digit_o   (dig),
    .cout_o    (dig_c),
    .invalid_o (dig_inv)
  );

  // Next-state, datapath shifting and output-register loads.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sub_d   = sub_q;
    c_d     = c_q;
    errf_d  = errf_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    dig_ext = '0;
    dig_ext[W-1 -: 4] = dig;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          errf_d  = 1'b0;
          c_d     = sub;   // the +1 of ten's complement enters as carry-in
          res_d   = '0;
        end
      end
      RUN: begin
        a_d    = a_q >> 4;
        b_d    = b_q >> 4;
        res_d  = (res_q >> 4) | dig_ext;
        c_d    = dig_c;
        errf_d = errf_q | dig_inv;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          sum_d   = (res_q >> 4) | dig_ext;
          cout_d  = dig_c;
          err_d   = errf_q | dig_inv;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      errf_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      errf_q  <= errf_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4 and DIGITS=1 instances).
module tb_bcd_serial_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        err;
    logic        exact;   // compare sum and cout (cleared for invalid-digit ops)
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, sub, ready, busy, done, cout, err;
  logic [15:0] a, b, sum;
  logic        start1, sub1, ready1, busy1, done1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   acc_q[$];
  int   acc1_q[$];
  exp_t e, e1;
  logic [15:0] last_sum;
  logic        last_cout, last_err, prev_done, prev_done1;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations on every done pulse, checks latency and hold.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      exp_q.delete(); acc_q.delete(); exp1_q.delete(); acc1_q.delete();
      last_sum = '0; last_cout = 1'b0; last_err = 1'b0;
      prev_done = 1'b0; prev_done1 = 1'b0;
    end else begin
      if (ready && start)   acc_q.push_back(cyc + 1);
      if (ready1 && start1) acc1_q.push_back(cyc + 1);
      if (done) begin
        done_cnt++;
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.exact) begin
            chk("sum", 32'(sum), 32'(e.sum));
            chk("cout", 32'(cout), 32'(e.cout));
          end
          chk("err", 32'(err), 32'(e.err));
          chk("latency", 32'(cyc - acc_q.pop_front()), 32'd4);
        end
        last_sum = sum; last_cout = cout; last_err = err;
      end else begin
        chk("outputs_hold", {14'd0, err, cout, sum}, {14'd0, last_err, last_cout, last_sum});
      end
      prev_done = done;
      if (done1) begin
        chk("done1_one_cycle", 32'(prev_done1), 32'd0);
        if (exp1_q.size() == 0 || acc1_q.size() == 0) begin
          chk("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e1 = exp1_q.pop_front();
          chk("sum1", 32'(sum1), 32'(e1.sum));
          chk("cout1", 32'(cout1), 32'(e1.cout));
          chk("err1", 32'(err1), 32'(e1.err));
          chk("latency1", 32'(cyc - acc1_q.pop_front()), 32'd1);
        end
      end
      prev_done1 = done1;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input logic s, input logic [15:0] av, input logic [15:0] bv,
                    input logic [15:0] es, input logic ec, input logic ee, input logic ex);
    wait_ready();
    a = av; b = bv; sub = s; start = 1'b1;
    exp_q.push_back('{sum: es, cout: ec, err: ee, exact: ex});
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
  endtask

  task automatic op1(input logic s, input logic [3:0] av, input logic [3:0] bv,
                     input logic [3:0] es, input logic ec);
    int n = 0;
    while (!ready1 && n < 50) begin @(negedge clk); n++; end
    if (!ready1) chk("ready1_timeout", 32'd0, 32'd1);
    a1 = av; b1 = bv; sub1 = s; start1 = 1'b1;
    exp1_q.push_back('{sum: {12'd0, es}, cout: ec, err: 1'b0, exact: 1'b1});
    @(negedge clk);
    start1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom);
  endtask

  initial begin
    int prev_acc;
    int dc;
    int n;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_outs", {14'd0, err, cout, sum}, 32'd0);
    chk("rst_ready1", 32'(ready1), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b1);
    op(1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
    op(1'b0, 16'h0999, 16'h0001, 16'h1000, 1'b0, 1'b0, 1'b1);
    op(1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b1, 1'b0, 1'b1);
    op(1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b0, 1'b0, 1'b1);
    op(1'b1, 16'h0042, 16'h0042, 16'h0000, 1'b1, 1'b0, 1'b1);
    op(1'b0, 16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    op(1'b1, 16'h0100, 16'h000B, 16'h0000, 1'b0, 1'b1, 1'b0);
    op(1'b0, 16'h0458, 16'h0367, 16'h0825, 1'b0, 1'b0, 1'b1);

    // start held high for 20 cycles; operands scrambled whenever not idle
    wait_ready();
    prev_acc = -1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ready) begin
        a = 16'h1234; b = 16'h5678; sub = 1'b0;
        exp_q.push_back('{sum: 16'h6912, cout: 1'b0, err: 1'b0, exact: 1'b1});
        if (prev_acc >= 0) chk("accept_spacing", 32'(cyc - prev_acc), 32'd6);
        prev_acc = cyc;
      end else begin
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain_held", 32'(exp_q.size()), 32'd0);

    // reset mid-RUN
    op(1'b0, 16'h4321, 16'h1111, 16'h5432, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_outs", {14'd0, err, cout, sum}, 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    dc = done_cnt;
    repeat (8) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt), 32'(dc));

    // single-digit instance
    op1(1'b0, 4'h9, 4'h9, 4'h8, 1'b1);
    op1(1'b1, 4'h3, 4'h7, 4'h6, 1'b0);
    op1(1'b1, 4'h7, 4'h3, 4'h4, 1'b1);
    op1(1'b0, 4'h2, 4'h5, 4'h7, 1'b0);
    n = 0;
    while ((exp_q.size() > 0 || exp1_q.size() > 0) && n < 100) begin @(negedge clk); n++; end
    chk("drain_final", 32'(exp_q.size() + exp1_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Parametrised, digit-serial packed-BCD adder/subtractor for multi-digit operands. It processes one BCD digit per clock, least-significant digit first, with a single one-digit decimal-correcting adder. It reports the final decimal carry or borrow and flags non-BCD input digits. It sits between operand registers and the BCD display/accumulator path, and replaces single-digit, purely combinational BCD addition wherever operands wider than one digit are needed.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand; legal range ≥ 1.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new operation; sampled only in IDLE.
- `sub`  in  1: 0 computes a+b; 1 computes a−b. Latched on accept.
- `a`  in  4·DIGITS: operand A, packed BCD, digit 0 in bits [3:0]. Latched on accept.
- `b`  in  4·DIGITS: operand B, packed BCD. Latched on accept.
- `ready`  out  1: high in IDLE.
- `busy`  out  1: high in RUN.
- `done`  out  1: one-cycle pulse; result outputs are valid from this cycle on.
- `sum`  out  4·DIGITS: packed BCD result.
- `cout`  out  1: for add, the decimal carry out; for sub, 1 when a ≥ b (no borrow).
- `err`  out  1: at least one digit of a or b was greater than 9 in the last operation.

## Operation
- States: IDLE, RUN, DONE. `ready`, `busy` and `done` decode directly from the state.
- IDLE → RUN when `start`=1.
  - On that edge: latch a, b, sub.
  - Clear the digit index and the internal error flag.
  - Preset the internal carry to `sub`.
- RUN: each edge processes digit i = index.
  - Operand digit: bd = sub ? (9 − b_i) : b_i, computed 4-bit.
  - t = a_i + bd + c, 5-bit.
  - If t > 9: digit = (t + 6) mod 16, c = 1. Otherwise digit = t, c = 0.
  - Shift the digit into the result shift register and increment the index.
  - Set the error flag if a_i > 9 or b_i > 9.
- RUN → DONE on the edge that processes digit DIGITS−1. On that same edge, load `sum`, `cout` and `err` from the final shift register, carry and error flag.
- DONE → IDLE unconditionally on the next edge.
- Subtraction uses ten's complement: a + (10^DIGITS − 1 − b) + 1.
  - If a < b: `sum` = 10^DIGITS − (b − a) and `cout` = 0.
- Invalid digits: `err`=1. The `sum` digits are unspecified, but the operation still completes with normal timing.
- `start` in RUN or DONE is ignored. There is no queueing.
- `sum`, `cout` and `err` are output registers. They change only on the edge entering DONE and hold until the next completion.

## Timing
- Reset (async assert, any state):
  - state = IDLE; `ready`=1, `busy`=0, `done`=0.
  - `sum`=0, `cout`=0, `err`=0; all internal registers 0.
- Reset mid-RUN aborts the operation: no `done` pulse, and outputs go to 0.
- Latency: let edge E accept `start`.
  - `done` is high in the cycle after edge E+DIGITS.
  - `ready` is high again after edge E+DIGITS+1.
- Throughput: with `start` held high, one accept every DIGITS+2 edges.
- Operand inputs may change freely after the accept edge.
- DIGITS=1: RUN lasts one edge; the same rules apply.

## Structure
- Package `bcd_pkg`:
  - state enum `bcd_state_t` {IDLE, RUN, DONE};
  - constants `BCD_MAX`=4'd9 and `BCD_CORR`=4'd6;
  - function `bcd_nines(d)` returning 9−d.
- Sub-module `bcd_digit_add`: combinational. Inputs a_i, bd, cin; outputs the corrected digit, cout, and an invalid flag. It is instantiated once.
- The top level holds the FSM, the index counter (width clog2(DIGITS)+1), the operand and result shift registers, and the output registers.

## Test plan
- DIGITS=4, add 0x1234 + 0x5678 → `sum`=0x6912, `cout`=0, `err`=0. `done` exactly 4 edges after the accept edge and for one cycle only.
- Add 0x9999 + 0x0001 → `sum`=0x0000, `cout`=1. Add 0x0999 + 0x0001 → `sum`=0x1000, `cout`=0 (carry ripple across digits).
- Sub 0x5000 − 0x1234 → `sum`=0x3766, `cout`=1. Sub 0x1234 − 0x5000 → `sum`=0x6234, `cout`=0. Sub 0x0042 − 0x0042 → `sum`=0x0000, `cout`=1.
- a=0x00A0, b=0x0001 → `err`=1. A following op 0x0001 + 0x0001 → `err`=0, `sum`=0x0002.
- `start` held high for 20 cycles → accepts spaced exactly 6 edges apart. Operands changed during RUN do not alter `sum`. `sum` stays stable between `done` pulses.
- `rst_n` pulsed low mid-RUN → all outputs 0 and `ready`=1 immediately, no `done`. Then DIGITS=1 build: 0x9 + 0x9 → `sum`=0x8, `cout`=1.
